// File: rtl/mdu_pkg.sv
// Purpose: shared opcodes and FSM state encoding for the multiply/divide unit.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mdu_neg.sv
// Purpose: conditional two's-complement negation, used for operand magnitudes and result sign fix-up.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module mdu_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  // The most negative value maps onto itself, which is exactly the unsigned magnitude wanted.
  assign res_o = neg_i ? (-val_i) : val_i;

endmodule

// File: rtl/mult_div_unit.sv
// Purpose: iterative MULT/MULTU/DIV/DIVU feeding the HI/LO registers; Done pulses the HI/LO load.
// Latency: WIDTH+2 cycles from accepted Start to Done (2 cycles for divide by zero).
// Backpressure: Start is ignored while Busy, except in the Done cycle where a new op is accepted.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH) + 1;
  // RUN spends one extra cycle at this count before FIX, giving the WIDTH+2 total latency.
  localparam logic [CW-1:0] ITER_LAST = CW'(WIDTH);

  state_e state_q, state_d;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;     // {high half / remainder, low half / quotient}
  logic [WIDTH-1:0]   bmag_q, bmag_d;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   araw_q, araw_d;   // raw dividend, returned on divide by zero
  logic               div_q, div_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;

  // Operand decode at capture time.
  logic             op_signed;
  logic             op_div;
  logic             sa_in;
  logic             sb_in;
  logic             accept;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign op_signed = (Op == OP_MULT) || (Op == OP_DIV);
  assign op_div    = (Op == OP_DIV)  || (Op == OP_DIVU);
  assign sa_in     = op_signed & A[WIDTH-1];
  assign sb_in     = op_signed & B[WIDTH-1];
  assign accept    = Start && ((state_q == S_IDLE) || (state_q == S_DONE));

  mdu_neg #(.W(WIDTH)) u_neg_a (.val_i(A), .neg_i(sa_in), .res_o(a_mag));
  mdu_neg #(.W(WIDTH)) u_neg_b (.val_i(B), .neg_i(sb_in), .res_o(b_mag));

  // One shift-add multiply step: add multiplicand into the high half when the low bit is set, then shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, bmag_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1:1]};

  // One restoring divide step: shift the partial remainder left by one dividend bit and trial-subtract.
  // The borrow out of the trial subtraction decides the quotient bit.
  logic [WIDTH:0]     div_tmp;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;

  assign div_tmp  = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_tmp - {1'b0, bmag_q};
  assign div_ge   = ~div_diff[WIDTH];
  assign div_next = div_ge ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                           : {div_tmp[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b0};

  // Sign fix-up: product takes sA^sB, quotient takes sA^sB, remainder takes the dividend's sign.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   hi_fix;
  logic [WIDTH-1:0]   lo_fix;

  mdu_neg #(.W(2*WIDTH)) u_neg_prod (.val_i(acc_q),                    .neg_i(sa_q ^ sb_q), .res_o(prod_fix));
  mdu_neg #(.W(WIDTH))   u_neg_quo  (.val_i(acc_q[WIDTH-1:0]),         .neg_i(sa_q ^ sb_q), .res_o(quo_fix));
  mdu_neg #(.W(WIDTH))   u_neg_rem  (.val_i(acc_q[2*WIDTH-1:WIDTH]),   .neg_i(sa_q),        .res_o(rem_fix));

  assign hi_fix = dz_q  ? araw_q :
                  div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign lo_fix = dz_q  ? {WIDTH{1'b1}} :
                  div_q ? quo_fix : prod_fix[WIDTH-1:0];

  // Next-state and datapath update; capture overrides the DONE->IDLE exit for back-to-back ops.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    bmag_d  = bmag_q;
    araw_d  = araw_q;
    div_d   = div_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (Start) state_d = S_RUN;
      end
      S_RUN: begin
        if (cnt_q == ITER_LAST) begin
          state_d = S_FIX;
        end else begin
          acc_d = div_q ? div_next : mul_next;
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FIX: begin
        state_d = S_DONE;
        hi_d    = hi_fix;
        lo_d    = lo_fix;
        dbz_d   = dz_q;
      end
      S_DONE: begin
        state_d = Start ? S_RUN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      // A zero divisor parks the counter at its last value so RUN exits straight away.
      dz_d   = op_div && (B == '0);
      cnt_d  = (op_div && (B == '0)) ? ITER_LAST : '0;
      acc_d  = {{WIDTH{1'b0}}, a_mag};
      bmag_d = b_mag;
      araw_d = A;
      div_d  = op_div;
      sa_d   = sa_in;
      sb_d   = sb_in;
      dbz_d  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and result registers; results are loaded only on the FIX->DONE step.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      bmag_q <= '0;
      araw_q <= '0;
      div_q  <= 1'b0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      dz_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      dbz_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      bmag_q <= bmag_d;
      araw_q <= araw_d;
      div_q  <= div_d;
      sa_q   <= sa_d;
      sb_q   <= sb_d;
      dz_q   <= dz_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      dbz_q  <= dbz_d;
    end
  end

  assign Busy      = (state_q != S_IDLE);
  assign Done      = (state_q == S_DONE);
  assign Hi        = hi_q;
  assign Lo        = lo_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Purpose: randomized and directed stimulus against a plain-arithmetic reference, scoreboard-checked.
// Latency: expects WIDTH+2 cycles per op, 2 for divide by zero.
// Backpressure: new ops are driven only when idle or in the Done cycle; one stray Start is driven while busy.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        Clk;
  logic        Rst_n;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        DivByZero;

  mult_div_unit #(.WIDTH(32)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Start     (Start),
    .Op        (Op),
    .A         (A),
    .B         (B),
    .Busy      (Busy),
    .Done      (Done),
    .Hi        (Hi),
    .Lo        (Lo),
    .DivByZero (DivByZero)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    int          done_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;
  logic        prev_done = 1'b0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: signed/unsigned 64-bit arithmetic, C-style truncating division.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sq;
    longint      sr;
    logic [63:0] v;
    e.dz = 1'b0;
    e.lat = 34;
    e.done_cyc = 0;
    e.hi = '0;
    e.lo = '0;
    case (op)
      OP_MULT: begin
        sq = longint'($signed(a)) * longint'($signed(b));
        v = sq;
        e.hi = v[63:32];
        e.lo = v[31:0];
      end
      OP_MULTU: begin
        v = {32'h0, a} * {32'h0, b};
        e.hi = v[63:32];
        e.lo = v[31:0];
      end
      default: begin
        if (b == 32'h0) begin
          e.dz = 1'b1;
          e.lat = 2;
          e.hi = a;
          e.lo = 32'hFFFF_FFFF;
        end else if (op == OP_DIV) begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          v = sq;
          e.lo = v[31:0];
          v = sr;
          e.hi = v[31:0];
        end else begin
          v = {32'h0, a} / {32'h0, b};
          e.lo = v[31:0];
          v = {32'h0, a} % {32'h0, b};
          e.hi = v[31:0];
        end
      end
    endcase
    return e;
  endfunction

  // Waits until the unit can accept (idle or Done cycle), drives Start for one edge, records the expectation.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   n;
    n = 0;
    @(negedge Clk);
    while (Busy && !Done && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (Busy && !Done) begin
      checks++;
      errors++;
      $display("FAIL issue_wait actual=busy required=accept_window (cycle %0d)", cyc);
    end else begin
      Start = 1'b1;
      Op = op;
      A = a;
      B = b;
      @(posedge Clk);
      #1;
      Start = 1'b0;
      e = model(op, a, b);
      e.done_cyc = cyc + e.lat;
      exp_q.push_back(e);
      check("busy_after_accept", {63'h0, Busy}, 64'h1);
      check("dbz_cleared_on_accept", {63'h0, DivByZero}, 64'h0);
    end
  endtask

  // Monitor: Busy tracks outstanding work, Done pops the scoreboard, Hi/Lo hold between Dones.
  always @(negedge Clk) begin
    exp_t e;
    check("busy", {63'h0, Busy}, {63'h0, (exp_q.size() != 0)});
    if (Done) begin
      check("done_not_consecutive", {63'h0, prev_done}, 64'h0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        check("hi", {32'h0, Hi}, {32'h0, e.hi});
        check("lo", {32'h0, Lo}, {32'h0, e.lo});
        check("div_by_zero", {63'h0, DivByZero}, {63'h0, e.dz});
        check("done_cycle", 64'(cyc), 64'(e.done_cyc));
        last_hi = e.hi;
        last_lo = e.lo;
      end
    end else if (!Rst_n) begin
      last_hi = '0;
      last_lo = '0;
    end else begin
      check("hi_hold", {32'h0, Hi}, {32'h0, last_hi});
      check("lo_hold", {32'h0, Lo}, {32'h0, last_lo});
    end
    prev_done = Done;
  end

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          sel;
    int          n;

    Start = 1'b0;
    Op = 2'b00;
    A = '0;
    B = '0;
    Rst_n = 1'b1;
    #1;
    Rst_n = 1'b0;
    #1;
    check("rst_busy", {63'h0, Busy}, 64'h0);
    check("rst_done", {63'h0, Done}, 64'h0);
    check("rst_hi", {32'h0, Hi}, 64'h0);
    check("rst_lo", {32'h0, Lo}, 64'h0);
    check("rst_dbz", {63'h0, DivByZero}, 64'h0);
    repeat (2) @(posedge Clk);
    #1;
    Rst_n = 1'b1;

    // Directed cases.
    issue(OP_MULT,  32'd7,         32'hFFFF_FFFD);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(OP_DIV,   32'hFFFF_FFF9, 32'd2);
    issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    issue(OP_DIVU,  32'd100,       32'd0);
    issue(OP_MULT,  32'd5,         32'hFFFF_FFFB);

    // Stray Start while busy must be ignored; the next op is then held in the Done cycle.
    issue(OP_MULTU, $urandom, $urandom);
    repeat (5) @(posedge Clk);
    #1;
    Start = 1'b1;
    Op = OP_DIV;
    A = $urandom;
    B = 32'd3;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    issue(OP_DIVU, $urandom, $urandom_range(1, 1000));

    // Randomized ops with corner-case bias and random idle gaps.
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 32'h0;
      if (sel == 1) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end
      if (sel == 2) rb = $urandom_range(1, 15);
      if (sel == 3) ra = $urandom_range(0, 100);
      repeat ($urandom_range(0, 2)) @(negedge Clk);
      issue(rop, ra, rb);
    end

    // Reset ten cycles into a DIV: outputs clear at once and no Done follows.
    issue(OP_DIV, 32'hDEAD_BEEF, 32'd13);
    repeat (10) @(posedge Clk);
    #1;
    Rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_busy", {63'h0, Busy}, 64'h0);
    check("midrst_done", {63'h0, Done}, 64'h0);
    check("midrst_hi", {32'h0, Hi}, 64'h0);
    check("midrst_lo", {32'h0, Lo}, 64'h0);
    repeat (2) @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    repeat (40) @(negedge Clk);

    issue(OP_DIVU, 32'd1000, 32'd7);

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d required=0 pending ops", exp_q.size());
    end
    repeat (3) @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
